reg_file: RTL and testbench

- Architectural register file with rename tags for the out-of-order RISC-V core.
- Sits between the issue unit and the reorder buffer. Issue reads source operands and renames rd to its ROB index; ROB commit writes retired values back.
- ROB index 0 is never allocated, so tag 0 means "no pending producer".
- Issue uses a nonzero returned tag to query the ROB for the value.

---
 rtl/reg_file.sv | 90 +++++++++
 tb/tb_reg_file.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags; combinational operand reads, commit/issue/flush updates.
// Optional commit-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,
   input  logic [4:0]           rs1_id,
   output logic [31:0]          rs1_val,
   output logic [ROB_WIDTH-1:0] rs1_depend,
   input  logic [4:0]           rs2_id,
   output logic [31:0]          rs2_val,
   output logic [ROB_WIDTH-1:0] rs2_depend,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic [ROB_WIDTH-1:0] issue_rob_idx,
   input  logic                 commit_valid,
   input  logic [4:0]           commit_rd,
   input  logic [ROB_WIDTH-1:0] commit_rob_idx,
   input  logic [31:0]          commit_val
);

   logic [31:0]          r_val [32];
   logic [ROB_WIDTH-1:0] r_tag [32];

   logic [31:0]          w_commit_hit;
   logic [31:0]          w_issue_hit;
   logic [31:0]          w_rs1_val;
   logic [ROB_WIDTH-1:0] w_rs1_dep;
   logic [31:0]          w_rs2_val;
   logic [ROB_WIDTH-1:0] w_rs2_dep;

   // One-hot write decode; bit 0 stays clear so x0 is never touched.
   always_comb begin
      w_commit_hit = '0;
      w_issue_hit  = '0;
      if (commit_valid && (commit_rd != 5'd0))
         w_commit_hit[commit_rd] = 1'b1;
      if (issue_valid && !clr_in && (issue_rd != 5'd0))
         w_issue_hit[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 32; i++) begin
            r_val[i] <= '0;
            r_tag[i] <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 1; i < 32; i++) begin
            if (w_commit_hit[i])
               r_val[i] <= commit_val;
            // Priority: flush, then a new rename, then release by the matching commit.
            if (clr_in)
               r_tag[i] <= '0;
            else if (w_issue_hit[i])
               r_tag[i] <= issue_rob_idx;
            else if (w_commit_hit[i] && (r_tag[i] == commit_rob_idx))
               r_tag[i] <= '0;
         end
      end
   end

   always_comb begin
      w_rs1_val = r_val[rs1_id];
      w_rs1_dep = r_tag[rs1_id];
      w_rs2_val = r_val[rs2_id];
      w_rs2_dep = r_tag[rs2_id];
`ifdef REGFILE_BYPASS_EN
      if (rdy_in && commit_valid && (rs1_id != 5'd0) && (commit_rd == rs1_id)
          && (r_tag[rs1_id] == commit_rob_idx)) begin
         w_rs1_val = commit_val;
         w_rs1_dep = '0;
      end
      if (rdy_in && commit_valid && (rs2_id != 5'd0) && (commit_rd == rs2_id)
          && (r_tag[rs2_id] == commit_rob_idx)) begin
         w_rs2_val = commit_val;
         w_rs2_dep = '0;
      end
`endif
   end

   assign rs1_val    = w_rs1_val;
   assign rs1_depend = w_rs1_dep;
   assign rs2_val    = w_rs2_val;
   assign rs2_depend = w_rs2_dep;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, younger producer, flush, x0, hold, stale commit, bypass, async reset.
module tb_reg_file;
   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          clr_in;
   logic [4:0]    rs1_id, rs2_id;
   logic [31:0]   rs1_val, rs2_val;
   logic [RW-1:0] rs1_depend, rs2_depend;
   logic          issue_valid;
   logic [4:0]    issue_rd;
   logic [RW-1:0] issue_rob_idx;
   logic          commit_valid;
   logic [4:0]    commit_rd;
   logic [RW-1:0] commit_rob_idx;
   logic [31:0]   commit_val;

   int errors = 0;
   int checks = 0;

   reg_file #(.ROB_WIDTH(RW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .rs1_id(rs1_id), .rs1_val(rs1_val), .rs1_depend(rs1_depend),
      .rs2_id(rs2_id), .rs2_val(rs2_val), .rs2_depend(rs2_depend),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_idx(issue_rob_idx),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_rob_idx(commit_rob_idx), .commit_val(commit_val)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      issue_valid  = 1'b0;
      commit_valid = 1'b0;
      clr_in       = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [RW-1:0] idx);
      issue_valid = 1'b1; issue_rd = rd; issue_rob_idx = idx;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [RW-1:0] idx, input logic [31:0] v);
      commit_valid = 1'b1; commit_rd = rd; commit_rob_idx = idx; commit_val = v;
   endtask

   task automatic rd1(input logic [4:0] id, input string tag, input logic [31:0] ev, input logic [RW-1:0] et);
      rs1_id = id;
      #1;
      check({tag, "_val"}, rs1_val, ev);
      check({tag, "_dep"}, 32'(rs1_depend), 32'(et));
   endtask

   task automatic rd2(input logic [4:0] id, input string tag, input logic [31:0] ev, input logic [RW-1:0] et);
      rs2_id = id;
      #1;
      check({tag, "_val"}, rs2_val, ev);
      check({tag, "_dep"}, 32'(rs2_depend), 32'(et));
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
      rs1_id = 5'd5; rs2_id = 5'd7;
      issue_valid = 1'b0; issue_rd = '0; issue_rob_idx = '0;
      commit_valid = 1'b0; commit_rd = '0; commit_rob_idx = '0; commit_val = '0;
      #2;
      rd1(5'd5, "reset_rs1", 32'h0, 4'd0);
      #10 rst_in = 1'b1;
      tick();

      // rename then commit
      issue(5'd5, 4'd3); tick();
      rd1(5'd5, "rename_x5", 32'h0, 4'd3);
      commit(5'd5, 4'd3, 32'hDEADBEEF); tick();
      rd1(5'd5, "commit_x5", 32'hDEADBEEF, 4'd0);

      // younger producer keeps its tag
      issue(5'd7, 4'd2); tick();
      issue(5'd7, 4'd4); tick();
      rd2(5'd7, "young_x7", 32'h0, 4'd4);
      commit(5'd7, 4'd2, 32'h11); tick();
      rd2(5'd7, "old_commit_x7", 32'h11, 4'd4);
      commit(5'd7, 4'd4, 32'h22); tick();
      rd2(5'd7, "young_commit_x7", 32'h22, 4'd0);

      // same edge issue + commit
      issue(5'd9, 4'd1); tick();
      issue(5'd9, 4'd6); commit(5'd9, 4'd1, 32'h55); tick();
      rd1(5'd9, "same_edge_x9", 32'h55, 4'd6);

      // flush
      issue(5'd1, 4'd1); tick();
      issue(5'd2, 4'd2); tick();
      issue(5'd3, 4'd3); tick();
      rd1(5'd3, "pre_flush_x3", 32'h0, 4'd3);
      clr_in = 1'b1; commit(5'd2, 4'd2, 32'h77); issue(5'd4, 4'd5); tick();
      rd1(5'd1, "flush_x1", 32'h0, 4'd0);
      rd1(5'd2, "flush_x2", 32'h77, 4'd0);
      rd2(5'd3, "flush_x3", 32'h0, 4'd0);
      rd2(5'd4, "flush_x4", 32'h0, 4'd0);
      rd1(5'd9, "flush_x9", 32'h55, 4'd0);

      // x0 ignored
      issue(5'd0, 4'd7); commit(5'd0, 4'd0, 32'hFFFF); tick();
      rd1(5'd0, "x0_rs1", 32'h0, 4'd0);

      // rdy_in low holds state
      rdy_in = 1'b0;
      issue(5'd10, 4'd3); commit(5'd5, 4'd0, 32'h123); tick();
      rd1(5'd10, "hold_x10", 32'h0, 4'd0);
      rd2(5'd5, "hold_x5", 32'hDEADBEEF, 4'd0);
      rdy_in = 1'b1;

      // stale commit writes value, keeps tag
      issue(5'd11, 4'd5); tick();
      commit(5'd11, 4'd3, 32'h99); tick();
      rd1(5'd11, "stale_x11", 32'h99, 4'd5);

      // same-cycle read of a committing register
      issue(5'd8, 4'd6); tick();
      commit(5'd8, 4'd6, 32'hABCD);
`ifdef REGFILE_BYPASS_EN
      rd2(5'd8, "bypass_x8", 32'hABCD, 4'd0);
`else
      rd2(5'd8, "nobypass_x8", 32'h0, 4'd6);
`endif
      tick();
      rd2(5'd8, "after_commit_x8", 32'hABCD, 4'd0);

      // async reset mid-run, no clock edge
      issue(5'd12, 4'd2); tick();
      rs1_id = 5'd5; rs2_id = 5'd12;
      #2 rst_in = 1'b0;
      #1;
      check("async_rst_rs1_val", rs1_val, 32'h0);
      check("async_rst_rs2_dep", 32'(rs2_depend), 32'h0);
      rd1(5'd8, "async_rst_x8", 32'h0, 4'd0);
      rd2(5'd11, "async_rst_x11", 32'h0, 4'd0);
      rst_in = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
